// File: rtl/nes_pkg.sv
// Shared definitions for the NES pad scanner: button indices, scan FSM
// encoding and the auto-repeat counter width helper.
package nes_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CLK_LO,
    CLK_HI,
    UPDATE
  } nes_state_t;

  // The repeat counter has to hold values up to repeat_delay.
  function automatic int rep_cnt_width(input int repeat_delay);
    return $clog2(repeat_delay + 1);
  endfunction

endpackage

// File: rtl/nes_button_tracker.sv
// Per-pad button state: latches each completed sample, emits press edges
// and auto-repeat events for the buttons selected by REPEAT_MASK.
module nes_button_tracker
  import nes_pkg::*;
#(
  parameter logic [7:0] REPEAT_MASK  = 8'hE0,
  parameter int         REPEAT_DELAY = 16,
  parameter int         REPEAT_RATE  = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       update,
  input  logic [7:0] sample,
  output logic [7:0] buttons,
  output logic [7:0] press_evt
);

  localparam int CW = rep_cnt_width(REPEAT_DELAY);
  localparam logic [CW-1:0] DELAY_C  = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RELOAD_C = CW'(REPEAT_DELAY - REPEAT_RATE);

  logic [CW-1:0] rep_cnt  [8];
  logic [CW-1:0] rep_next [8];
  logic [7:0]    rep_fire;
  logic [7:0]    edge_evt;

  assign edge_evt = sample & ~buttons;

  // rep_cnt holds polls since the last event; reloading to DELAY-RATE after
  // a repeat makes later events land every REPEAT_RATE polls.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      rep_fire[i] = 1'b0;
      rep_next[i] = rep_cnt[i];
      if (!REPEAT_MASK[i] || !sample[i] || edge_evt[i]) begin
        rep_next[i] = '0;
      end else if (rep_cnt[i] + CW'(1) == DELAY_C) begin
        rep_fire[i] = 1'b1;
        rep_next[i] = RELOAD_C;
      end else begin
        rep_next[i] = rep_cnt[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buttons   <= '0;
      press_evt <= '0;
      // NOTE: this counter array is small control state, so it is reset; bulk data RAMs would not be.
      for (int i = 0; i < 8; i++) rep_cnt[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      press_evt <= '0;
      if (update) begin
        buttons   <= sample;
        press_evt <= edge_evt | rep_fire;
        for (int i = 0; i < 8; i++) rep_cnt[i] <= rep_next[i];
      end
    end
  end

endmodule

// File: rtl/nes_pad_scanner.sv
// Multi-pad NES controller scanner: drives the shared latch/clock, shifts in
// every pad in parallel and raises a Start+Select hold-to-reset request.
module nes_pad_scanner
  import nes_pkg::*;
#(
  parameter int         NUM_PADS     = 2,
  parameter int         HALF_BIT     = 300,
  parameter int         POLL_PERIOD  = 833333,
  parameter logic [7:0] REPEAT_MASK  = 8'hE0,
  parameter int         REPEAT_DELAY = 16,
  parameter int         REPEAT_RATE  = 6,
  parameter int         HOLD_RESET   = 60
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_PADS-1:0]   nes_data,
  output logic                  nes_latch,
  output logic                  nes_clock,
  output logic [8*NUM_PADS-1:0] buttons,
  output logic [8*NUM_PADS-1:0] press_evt,
  output logic                  frame_valid,
  output logic                  nes_reset
);

  localparam int PW  = $clog2(2 * HALF_BIT);
  localparam int PCW = $clog2(POLL_PERIOD);
  localparam int HW  = $clog2(HOLD_RESET + 1);
  localparam logic [PW-1:0]  LATCH_LAST = PW'(2 * HALF_BIT - 1);
  localparam logic [PW-1:0]  PHASE_LAST = PW'(HALF_BIT - 1);
  localparam logic [PCW-1:0] POLL_LAST  = PCW'(POLL_PERIOD - 1);
  localparam logic [HW-1:0]  HOLD_C     = HW'(HOLD_RESET);

  nes_state_t     state;
  logic [PW-1:0]  phase_cnt;
  logic [2:0]     bit_idx;
  logic [PCW-1:0] poll_cnt;
  logic [6:0]     shift_q [NUM_PADS];
  logic           sample_strobe;
  logic [HW-1:0]  hold_cnt;
  logic           hold_lock;

  // Bit 7 bypasses the shift register so results appear the cycle after the last sample.
  assign sample_strobe = (state == CLK_LO) && (phase_cnt == PHASE_LAST) && (bit_idx == 3'd7);

  always_ff @(posedge clk) begin
    if (reset || poll_cnt == POLL_LAST) poll_cnt <= '0;
    else                                poll_cnt <= poll_cnt + PCW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      nes_latch   <= 1'b0;
      nes_clock   <= 1'b0;
      frame_valid <= 1'b0;
      phase_cnt   <= '0;
      bit_idx     <= '0;
      for (int p = 0; p < NUM_PADS; p++) shift_q[p] <= '0;
    end else begin
      frame_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (poll_cnt == '0) begin
            state     <= LATCH;
            nes_latch <= 1'b1;
            phase_cnt <= '0;
          end
        end
        LATCH: begin
          if (phase_cnt == LATCH_LAST) begin
            state     <= CLK_LO;
            nes_latch <= 1'b0;
            phase_cnt <= '0;
            bit_idx   <= '0;
          end else begin
            phase_cnt <= phase_cnt + PW'(1);
          end
        end
        CLK_LO: begin
          if (phase_cnt == PHASE_LAST) begin
            phase_cnt <= '0;
            for (int p = 0; p < NUM_PADS; p++) shift_q[p] <= {~nes_data[p], shift_q[p][6:1]};
            if (bit_idx == 3'd7) begin
              state       <= UPDATE;
              frame_valid <= 1'b1;
            end else begin
              state     <= CLK_HI;
              nes_clock <= 1'b1;
            end
          end else begin
            phase_cnt <= phase_cnt + PW'(1);
          end
        end
        CLK_HI: begin
          if (phase_cnt == PHASE_LAST) begin
            state     <= CLK_LO;
            nes_clock <= 1'b0;
            phase_cnt <= '0;
            bit_idx   <= bit_idx + 3'd1;
          end else begin
            phase_cnt <= phase_cnt + PW'(1);
          end
        end
        UPDATE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    nes_button_tracker #(
      .REPEAT_MASK  (REPEAT_MASK),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_tracker (
      .clk       (clk),
      .reset     (reset),
      .update    (sample_strobe),
      .sample    ({~nes_data[p], shift_q[p]}),
      .buttons   (buttons[8*p +: 8]),
      .press_evt (press_evt[8*p +: 8])
    );
  end

  // hold_lock keeps the request from re-firing until Start and Select are both let go.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt  <= '0;
      hold_lock <= 1'b0;
      nes_reset <= 1'b0;
    end else begin
      nes_reset <= 1'b0;
      if (state == UPDATE) begin
        if (buttons[BTN_START] && buttons[BTN_SELECT]) begin
          if (!hold_lock) begin
            if (hold_cnt + HW'(1) == HOLD_C) begin
              nes_reset <= 1'b1;
              hold_lock <= 1'b1;
              hold_cnt  <= '0;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
        end else begin
          hold_cnt <= '0;
          if (!buttons[BTN_START] && !buttons[BTN_SELECT]) hold_lock <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_nes_pad_scanner.sv
// Directed bench for nes_pad_scanner with behavioural shift-register pads
// that follow the DUT's latch and clock pins.
module tb_nes_pad_scanner;

  localparam int NP = 2;
  localparam int HB = 4;
  localparam int PP = 200;
  localparam int RD = 3;
  localparam int RR = 2;
  localparam int HR = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NP-1:0]   nes_data;
  logic            nes_latch;
  logic            nes_clock;
  logic [8*NP-1:0] buttons;
  logic [8*NP-1:0] press_evt;
  logic            frame_valid;
  logic            nes_reset;

  int errors = 0;
  int checks = 0;

  logic [7:0] pad_wire [NP];
  int sidx = 8;
  int rst_pulses = 0;

  always #5 clk = ~clk;

  nes_pad_scanner #(
    .NUM_PADS     (NP),
    .HALF_BIT     (HB),
    .POLL_PERIOD  (PP),
    .REPEAT_MASK  (8'hE0),
    .REPEAT_DELAY (RD),
    .REPEAT_RATE  (RR),
    .HOLD_RESET   (HR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .nes_data    (nes_data),
    .nes_latch   (nes_latch),
    .nes_clock   (nes_clock),
    .buttons     (buttons),
    .press_evt   (press_evt),
    .frame_valid (frame_valid),
    .nes_reset   (nes_reset)
  );

  // Pad model: latch loads bit 0 (A) onto the line, each clock rise moves on.
  always @(posedge nes_latch or posedge nes_clock) begin
    if (nes_latch) sidx = 0;
    else           sidx = sidx + 1;
  end

  always_comb begin
    for (int p = 0; p < NP; p++) nes_data[p] = (sidx < 8) ? pad_wire[p][7 - sidx] : 1'b1;
  end

  always @(negedge clk) if (nes_reset) rst_pulses = rst_pulses + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required the bench to finish");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_frame(output logic [15:0] b, output logic [15:0] e,
                            output logic [15:0] e_after, output logic fv_after,
                            output int pulses);
    int  start;
    bit  got;
    start = rst_pulses;
    got   = 1'b0;
    for (int i = 0; i < 2 * PP && !got; i++) begin
      @(negedge clk);
      if (frame_valid) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL frame_timeout: no frame_valid within %0d cycles, required one", 2 * PP);
    end
    b = buttons;
    e = press_evt;
    @(negedge clk);
    e_after  = press_evt;
    fv_after = frame_valid;
    @(negedge clk);
    pulses = rst_pulses - start;
  endtask

  task automatic test_reset();
    logic exp_latch, exp_clock, exp_fv;
    int   fv_cycle;
    pad_wire[0] = 8'hFF;
    pad_wire[1] = 8'hFF;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({nes_latch, nes_clock, frame_valid, nes_reset, buttons, press_evt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: latch=%b clock=%b fv=%b rst=%b buttons=%h press=%h, required all 0",
               nes_latch, nes_clock, frame_valid, nes_reset, buttons, press_evt);
    end
    reset = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      exp_latch = (c >= 1 && c <= 8);
      exp_clock = (c >= 13 && c <= 68 && ((c - 13) % 8) < 4);
      exp_fv    = (c == 69);
      checks += 3;
      if (nes_latch !== exp_latch) begin
        errors++;
        $display("FAIL latch_timing cycle %0d: got %b, required %b", c, nes_latch, exp_latch);
      end
      if (nes_clock !== exp_clock) begin
        errors++;
        $display("FAIL clock_timing cycle %0d: got %b, required %b", c, nes_clock, exp_clock);
      end
      if (frame_valid !== exp_fv) begin
        errors++;
        $display("FAIL frame_timing cycle %0d: got %b, required %b", c, frame_valid, exp_fv);
      end
    end
    fv_cycle = 0;
    for (int c = 71; c <= 300 && fv_cycle == 0; c++) begin
      @(negedge clk);
      if (frame_valid) fv_cycle = c;
    end
    checks++;
    if (fv_cycle != 269) begin
      errors++;
      $display("FAIL second_frame: frame_valid at cycle %0d, required 269", fv_cycle);
    end
    checks++;
    if (buttons !== 16'h0000) begin
      errors++;
      $display("FAIL idle_buttons: got %h, required 0000", buttons);
    end
  endtask

  task automatic test_press();
    logic [15:0] b, e, ea;
    logic        fva;
    int          pl;
    pad_wire[0] = 8'h7F;
    pad_wire[1] = 8'hFF;
    wait_frame(b, e, ea, fva, pl);
    checks += 4;
    if (b !== 16'h0001) begin errors++; $display("FAIL press_buttons: got %h, required 0001", b); end
    if (e !== 16'h0001) begin errors++; $display("FAIL press_evt: got %h, required 0001", e); end
    if (ea !== 16'h0000) begin errors++; $display("FAIL press_evt_width: next cycle %h, required 0000", ea); end
    if (fva !== 1'b0) begin errors++; $display("FAIL frame_width: next cycle %b, required 0", fva); end
    wait_frame(b, e, ea, fva, pl);
    checks += 2;
    if (b !== 16'h0001) begin errors++; $display("FAIL held_buttons: got %h, required 0001", b); end
    if (e !== 16'h0000) begin errors++; $display("FAIL held_no_evt: got %h, required 0000", e); end
  endtask

  task automatic test_repeat();
    logic [15:0] b, e, ea, exp_e;
    logic        fva;
    int          pl;
    pad_wire[1] = 8'hFD;
    for (int k = 0; k < 8; k++) begin
      wait_frame(b, e, ea, fva, pl);
      exp_e = (k == 0 || k == 3 || k == 5 || k == 7) ? 16'h4000 : 16'h0000;
      checks += 2;
      if (b !== 16'h4001) begin errors++; $display("FAIL repeat_buttons k=%0d: got %h, required 4001", k, b); end
      if (e !== exp_e) begin errors++; $display("FAIL repeat_evt k=%0d: got %h, required %h", k, e, exp_e); end
    end
  endtask

  task automatic test_repress();
    logic [15:0] b, e, ea, exp_e;
    logic        fva;
    int          pl;
    pad_wire[1] = 8'hFF;
    wait_frame(b, e, ea, fva, pl);
    checks += 2;
    if (b !== 16'h0001) begin errors++; $display("FAIL release_buttons: got %h, required 0001", b); end
    if (e !== 16'h0000) begin errors++; $display("FAIL release_evt: got %h, required 0000", e); end
    pad_wire[1] = 8'hFD;
    for (int k = 0; k < 6; k++) begin
      wait_frame(b, e, ea, fva, pl);
      exp_e = (k == 0 || k == 3 || k == 5) ? 16'h4000 : 16'h0000;
      checks++;
      if (e !== exp_e) begin errors++; $display("FAIL repress_evt k=%0d: got %h, required %h", k, e, exp_e); end
    end
  endtask

  task automatic test_hold_reset();
    logic [15:0] b, e, ea;
    logic        fva;
    int          pl, exp_pl;
    pad_wire[0] = 8'hCF;
    pad_wire[1] = 8'hFF;
    for (int k = 1; k <= 6; k++) begin
      wait_frame(b, e, ea, fva, pl);
      exp_pl = (k == 4) ? 1 : 0;
      checks++;
      if (pl != exp_pl) begin errors++; $display("FAIL hold_pulse poll %0d: got %0d, required %0d", k, pl, exp_pl); end
      if (k == 1) begin
        checks += 2;
        if (b !== 16'h000C) begin errors++; $display("FAIL hold_buttons: got %h, required 000C", b); end
        if (e !== 16'h000C) begin errors++; $display("FAIL hold_evt: got %h, required 000C", e); end
      end
    end
    pad_wire[0] = 8'hFF;
    pad_wire[1] = 8'hCF;
    for (int k = 1; k <= 5; k++) begin
      wait_frame(b, e, ea, fva, pl);
      checks++;
      if (pl != 0) begin errors++; $display("FAIL pad1_hold poll %0d: got %0d pulses, required 0", k, pl); end
    end
    pad_wire[0] = 8'hCF;
    pad_wire[1] = 8'hFF;
    for (int k = 1; k <= 4; k++) begin
      wait_frame(b, e, ea, fva, pl);
      exp_pl = (k == 4) ? 1 : 0;
      checks++;
      if (pl != exp_pl) begin errors++; $display("FAIL rehold_pulse poll %0d: got %0d, required %0d", k, pl, exp_pl); end
    end
  endtask

  task automatic test_midscan_reset();
    logic [15:0] b, e, ea;
    logic        fva;
    int          pl, bad, fv_cycle;
    bit          found;
    pad_wire[0] = 8'h7F;
    pad_wire[1] = 8'hFF;
    wait_frame(b, e, ea, fva, pl);
    found = 1'b0;
    for (int i = 0; i < 2 * PP && !found; i++) begin
      @(negedge clk);
      if (nes_clock && sidx == 4) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL midscan_find: CLK_HI of bit 3 not seen, required it"); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({nes_latch, nes_clock, frame_valid, buttons, press_evt} !== '0) begin
      errors++;
      $display("FAIL midscan_abort: latch=%b clock=%b fv=%b buttons=%h press=%h, required all 0",
               nes_latch, nes_clock, frame_valid, buttons, press_evt);
    end
    bad = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (nes_latch || nes_clock || frame_valid) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL reset_quiet: %0d active cycles during reset, required 0", bad); end
    reset = 1'b0;
    fv_cycle = 0;
    for (int c = 1; c <= 100 && fv_cycle == 0; c++) begin
      @(negedge clk);
      if (frame_valid) begin
        fv_cycle = c;
        b = buttons;
        e = press_evt;
      end
    end
    checks += 3;
    if (fv_cycle != 69) begin errors++; $display("FAIL restart_frame: at cycle %0d, required 69", fv_cycle); end
    if (b !== 16'h0001) begin errors++; $display("FAIL restart_buttons: got %h, required 0001", b); end
    if (e !== 16'h0001) begin errors++; $display("FAIL restart_evt: got %h, required 0001", e); end
  endtask

  initial begin
    test_reset();
    test_press();
    test_repeat();
    test_repress();
    test_hold_reset();
    test_midscan_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nes_pad_scanner.md
Name: nes_pad_scanner

Overview:
- Parametrised successor to the single-pad NES input controller.
- Drives a shared latch/clock pair for NUM_PADS controllers and shifts in each pad's serial data line in parallel.
- Publishes debounced per-poll button levels, one-cycle press events with programmable auto-repeat (DAS), and a Start+Select hold-to-reset request.
- Sits between the pad pins and the grid controller / top-level reset logic.

Parameters:
- NUM_PADS, 2: number of controllers sharing nes_latch/nes_clock.
- HALF_BIT, 300: cycles per latch half-width and per clock phase (6 us at 50 MHz).
- POLL_PERIOD, 833333: cycles between poll starts (60 Hz). Must be >= 17*HALF_BIT+2.
- REPEAT_MASK, 8'hE0: buttons eligible for auto-repeat (Down, Left, Right).
- REPEAT_DELAY, 16: held polls before the first repeat event; must be >= 1.
- REPEAT_RATE, 6: held polls between later repeat events; must be >= 1 and <= REPEAT_DELAY.
- HOLD_RESET, 60: consecutive polls pad 0 must hold Start+Select before nes_reset fires.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high.
- nes_data, in, NUM_PADS: serial data per pad, active-low.
- nes_latch, out, 1: pad latch strobe.
- nes_clock, out, 1: pad shift clock.
- buttons, out, 8*NUM_PADS: pad p occupies [8p+7:8p], 1 = held. Bit order: 0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
- press_evt, out, 8*NUM_PADS: one-cycle pulse per new press or auto-repeat.
- frame_valid, out, 1: one-cycle pulse when buttons/press_evt update.
- nes_reset, out, 1: one-cycle reset request.

Behaviour:
- Reset values: all outputs 0. State IDLE. Poll counter, shift registers, repeat counters and hold counter all 0.
- While reset is high, no scan runs. Reset asserted mid-scan aborts it immediately; buttons do not update.
- FSM states: IDLE, LATCH, CLK_LO, CLK_HI, UPDATE. All outputs registered.
- Poll start (t0): in the cycle poll counter == 0 while in IDLE, go to LATCH. The first t0 is the first cycle after reset deasserts.
- LATCH: nes_latch=1 for 2*HALF_BIT cycles, then CLK_LO with bit index i=0.
- CLK_LO: nes_clock=0 for HALF_BIT cycles. On the last cycle, shift in ~nes_data[p] as bit i for every pad.
  - If i==7, go to UPDATE.
  - Otherwise go to CLK_HI.
- CLK_HI: nes_clock=1 for HALF_BIT cycles, then i++ and return to CLK_LO.
- UPDATE: one cycle, then IDLE.
  - buttons, press_evt and frame_valid become visible at t0+17*HALF_BIT+1.
  - press_evt and frame_valid are high for exactly that one cycle.
- Poll counter wraps POLL_PERIOD-1 -> 0 independently of the FSM.
- Edge event: press_evt bit = new & ~old.
- Auto-repeat, masked bits only, counted per pad per button in polls:
  - The press poll is k=0. Further events fire at k=REPEAT_DELAY, REPEAT_DELAY+REPEAT_RATE, and so on.
  - Releasing the button clears its counter. A re-press restarts at k=0.
  - Unmasked bits emit only the edge event.
- Simultaneous edge and repeat on the same bit is impossible by construction; never emit two pulses.
- Hold reset:
  - The counter increments each UPDATE while pad 0 has Start and Select both held, and clears when either is released.
  - nes_reset pulses for one cycle when the count reaches HOLD_RESET.
  - It then stays disarmed until both buttons are released; continued holding does not re-fire.
- Pads beyond pad 0 never affect nes_reset.
- A disconnected pad (pulled-up data) reads all-released.

Decomposition:
- Shared package nes_pkg holds:
  - button index localparams BTN_A..BTN_RIGHT;
  - FSM state encoding;
  - the repeat-counter width function, clog2(REPEAT_DELAY+1).
- Sub-module nes_button_tracker, instantiated once per pad. It takes the new 8-bit sample and an update strobe, and produces buttons, press_evt and repeat state.
- The hold-reset logic lives in the top-level block on pad 0's outputs.

Test Plan (HALF_BIT=4, POLL_PERIOD=200, REPEAT_DELAY=3, REPEAT_RATE=2, HOLD_RESET=4, NUM_PADS=2):
- Reset release -> nes_latch high cycles 1-8, then 8 low / 7 high clock phases of 4 cycles each. frame_valid at cycle 69 and again at 269.
- Pad 0 serial 0x7F on the wire (A pressed), pad 1 0xFF -> buttons=16'h0001. press_evt=16'h0001 for one cycle. Next poll press_evt=0.
- Pad 1 holds Left for 8 polls -> press_evt bit 14 pulses at polls 0, 3, 5, 7. Pad 0 holding A gives only the poll-0 pulse.
- Pad 0 holds Start+Select -> nes_reset one pulse at the 4th UPDATE, none while still held. After release and re-hold, it fires again after 4 polls.
- Reset asserted during CLK_HI of bit 3 -> nes_latch/nes_clock 0 next cycle, buttons 0, no frame_valid. A fresh scan starts after release.
- Left pressed, released for one poll, re-pressed -> edge event on re-press. Repeat timing restarts from k=0.
